bcd_convert_arbiter: RTL and testbench

- Shares one iterative 8-bit binary-to-BCD (shift-add-3) conversion engine among N_REQ requesters, e.g. display channels and counters.
- Arbitrates round-robin and captures the winner's value.
- Sequences the 8 shift/correct cycles, then presents hundreds/tens/ones tagged with the requester id on a valid/ready response port.
- Sits between the value producers and the seven-segment or display formatting logic.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_dd_engine.sv | 47 ++++
 rtl/bcd_convert_arbiter.sv | 141 ++++++++++++++
 tb/tb_bcd_convert_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared widths, state encoding and the double-dabble nibble correction
// used by the BCD conversion arbiter and its engine.
package bcd_pkg;

    localparam int BIN_W        = 8;
    localparam int BCD_W        = 4;
    localparam int SHIFT_CYCLES = 8;
    localparam int SR_W         = 20;
    localparam int CNT_W        = $clog2(SHIFT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_e;

    // A digit of 5 or more would exceed 9 after doubling, so it is pre-biased by 3.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] n);
        return (n >= BCD_W'(5)) ? n + BCD_W'(3) : n;
    endfunction

endpackage

// File: rtl/bcd_dd_engine.sv
// Iterative shift-add-3 engine: load an 8-bit value, then one correct+shift per step.
// The step_* outputs are the digits the register will hold once the current step lands.
module bcd_dd_engine
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BIN_W-1:0] load_val_i,
    input  logic             step_i,
    output logic [BCD_W-1:0] step_hundreds_o,
    output logic [BCD_W-1:0] step_tens_o,
    output logic [BCD_W-1:0] step_ones_o
);

    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_d;
    logic [SR_W-1:0] corr;
    logic [SR_W-1:0] stepped;

    always_comb begin
        corr          = sr_q;
        corr[19:16]   = add3(sr_q[19:16]);
        corr[15:12]   = add3(sr_q[15:12]);
        corr[11:8]    = add3(sr_q[11:8]);
        stepped       = {corr[SR_W-2:0], 1'b0};
        sr_d          = sr_q;
        if (load_i) begin
            sr_d = {{(SR_W-BIN_W){1'b0}}, load_val_i};
        end else if (step_i) begin
            sr_d = stepped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign step_hundreds_o = stepped[19:16];
    assign step_tens_o     = stepped[15:12];
    assign step_ones_o     = stepped[11:8];

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD engine among N_REQ requesters,
// returning hundreds/tens/ones tagged with the requester id over valid/ready.
module bcd_convert_arbiter
    import bcd_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [BIN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [BCD_W-1:0]       rsp_hundreds,
    output logic [BCD_W-1:0]       rsp_tens,
    output logic [BCD_W-1:0]       rsp_ones
);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cool_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [BCD_W-1:0]   rsp_hundreds_q;
    logic [BCD_W-1:0]   rsp_tens_q;
    logic [BCD_W-1:0]   rsp_ones_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cand;
    logic [BIN_W-1:0]   win_data;
    logic [ID_W-1:0]    ptr_next;
    logic               grant_fire;
    logic [BCD_W-1:0]   eng_hundreds;
    logic [BCD_W-1:0]   eng_tens;
    logic [BCD_W-1:0]   eng_ones;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                win_data = req_data[i*BIN_W +: BIN_W];
            end
        end
    end

    // One turnaround cycle in IDLE after each handshake before arbitrating again.
    assign grant_fire = (state_q == IDLE) && !cool_q && win_found;
    assign ptr_next   = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;

    always_comb begin
        gnt = '0;
        if (rst_n && grant_fire) begin
            gnt[win_id] = 1'b1;
        end
    end

    bcd_dd_engine u_engine (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_i          (grant_fire),
        .load_val_i      (win_data),
        .step_i          (state_q == SHIFT),
        .step_hundreds_o (eng_hundreds),
        .step_tens_o     (eng_tens),
        .step_ones_o     (eng_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            id_q           <= '0;
            cnt_q          <= '0;
            cool_q         <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_hundreds_q <= '0;
            rsp_tens_q     <= '0;
            rsp_ones_q     <= '0;
        end else begin
            cool_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        state_q <= SHIFT;
                        id_q    <= win_id;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) begin
                        state_q        <= RESP;
                        rsp_valid_q    <= 1'b1;
                        rsp_id_q       <= id_q;
                        rsp_hundreds_q <= eng_hundreds;
                        rsp_tens_q     <= eng_tens;
                        rsp_ones_q     <= eng_ones;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_next;
                        cool_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_hundreds = rsp_hundreds_q;
    assign rsp_tens     = rsp_tens_q;
    assign rsp_ones     = rsp_ones_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter: arbitration order, fixed latency,
// digit values at the boundaries, backpressure and reset abandonment.
module tb_bcd_convert_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        rsp_ready = 1'b1;
    logic [3:0]  gnt;
    logic        busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_hundreds;
    logic [3:0]  rsp_tens;
    logic [3:0]  rsp_ones;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bcd_convert_arbiter #(.N_REQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .busy         (busy),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_hundreds (rsp_hundreds),
        .rsp_tens     (rsp_tens),
        .rsp_ones     (rsp_ones)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stepTo();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        req      = r;
        req_data = d;
    endtask

    // Waits for a grant, checks which requester got it, then retires that request.
    task automatic waitGrant(input int expId, output int gc);
        bit found = 1'b0;
        gc = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                found = 1'b1;
                gc    = cyc;
            end
        end
        if (!found) begin
            checkOutput("grantTimeout", 32'd0, 32'd1);
        end else begin
            checkOutput("gnt", 32'(gnt), 32'd1 << expId);
            stepTo();
            req[expId[1:0]] = 1'b0;
        end
    endtask

    task automatic waitResp(input int expId, input int h, input int t, input int o, input int gc);
        bit found = 1'b0;
        int vc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                vc    = cyc;
            end
        end
        if (!found) begin
            checkOutput("rspTimeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", 32'(vc - gc), 32'd9);
            checkOutput("rspId", 32'(rsp_id), 32'(expId));
            checkOutput("digits", 32'({rsp_hundreds, rsp_tens, rsp_ones}),
                        32'({h[3:0], t[3:0], o[3:0]}));
            checkOutput("busyInResp", 32'(busy), 32'd1);
        end
    endtask

    task automatic runOne(input int expId, input int h, input int t, input int o, output int gc);
        waitGrant(expId, gc);
        waitResp(expId, h, t, o, gc);
    endtask

    initial begin
        int g0, g1, g2, g3, g, hs, spurious;
        int vals[5] = '{255, 0, 99, 100, 9};
        int eh[5]   = '{2, 0, 0, 1, 0};
        int et[5]   = '{5, 0, 9, 0, 0};
        int eo[5]   = '{5, 0, 9, 0, 9};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetGnt", 32'(gnt), 32'd0);
        checkOutput("resetFlags", 32'({busy, rsp_valid}), 32'd0);
        checkOutput("resetRsp", 32'({rsp_id, rsp_hundreds, rsp_tens, rsp_ones}), 32'd0);
        stepTo();
        rst_n = 1'b1;

        // All four requesting from pointer 0: served in index order, 11 cycles apart.
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10});
        runOne(0, 0, 1, 0, g0);
        runOne(1, 0, 2, 0, g1);
        checkOutput("spacing01", 32'(g1 - g0), 32'd11);
        runOne(2, 0, 3, 0, g2);
        checkOutput("spacing12", 32'(g2 - g1), 32'd11);
        runOne(3, 0, 4, 0, g3);
        checkOutput("spacing23", 32'(g3 - g2), 32'd11);

        for (int k = 0; k < 5; k++) begin
            stepTo();
            applyStimulus(4'b0001, {24'd0, 8'(vals[k])});
            runOne(0, eh[k], et[k], eo[k], g);
        end

        // Serve id 1 so the pointer sits at 2, then 3 -> 0 -> 1.
        stepTo();
        applyStimulus(4'b0010, {8'd0, 8'd0, 8'd55, 8'd0});
        runOne(1, 0, 5, 5, g);
        stepTo();
        applyStimulus(4'b1011, {8'd200, 8'd0, 8'd128, 8'd7});
        runOne(3, 2, 0, 0, g);
        runOne(0, 0, 0, 7, g);
        runOne(1, 1, 2, 8, g);

        // Backpressure with a waiting requester.
        stepTo();
        rsp_ready = 1'b0;
        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd250, 8'd63});
        runOne(0, 0, 6, 3, g);
        for (int k = 0; k < 5; k++) begin
            stepTo();
            if (k == 0) req = 4'b0010;
            @(negedge clk);
            checkOutput("holdDigits", 32'({rsp_hundreds, rsp_tens, rsp_ones}), 32'h063);
            checkOutput("holdId", 32'(rsp_id), 32'd0);
            checkOutput("holdFlags", 32'({rsp_valid, busy, gnt}), 32'h30);
        end
        stepTo();
        rsp_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
        checkOutput("validAtHandshake", 32'(rsp_valid), 32'd1);
        stepTo();
        @(negedge clk);
        checkOutput("afterHsFlags", 32'({rsp_valid, busy, gnt}), 32'd0);
        checkOutput("retainDigits", 32'({rsp_hundreds, rsp_tens, rsp_ones}), 32'h063);
        runOne(1, 2, 5, 0, g);
        checkOutput("regrantDelay", 32'(g - hs), 32'd2);

        // Reset at shift count 4 abandons the conversion immediately.
        stepTo();
        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd77});
        waitGrant(0, g);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetFlags", 32'({gnt, busy, rsp_valid}), 32'd0);
        checkOutput("midResetRsp", 32'({rsp_id, rsp_hundreds, rsp_tens, rsp_ones}), 32'd0);
        applyStimulus(4'b0110, {8'd0, 8'd99, 8'd137, 8'd0});
        @(negedge clk);
        checkOutput("gntInReset", 32'(gnt), 32'd0);
        stepTo();
        stepTo();
        rst_n = 1'b1;
        waitGrant(1, g);
        applyStimulus(4'b0000, {8'd0, 8'd99, 8'd137, 8'd0});
        waitResp(1, 1, 3, 7, g);

        // A request pulsed while busy is never granted.
        stepTo();
        applyStimulus(4'b0001, {8'd0, 8'd99, 8'd0, 8'd42});
        waitGrant(0, g);
        stepTo();
        req[2] = 1'b1;
        stepTo();
        req[2] = 1'b0;
        waitResp(0, 0, 4, 2, g);
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt != 4'b0 || rsp_valid) spurious++;
        end
        checkOutput("noSpurious", 32'(spurious), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
